// File: rtl/micro_processor_pkg.sv
// micro_processor_pkg: shared constants for the push-button ALU.
//   OPERAND_WIDTH : width of each unsigned operand packed into data_in
//   OP_*          : 3-bit opcode encodings selecting the ALU function
package micro_processor_pkg;

  localparam int unsigned OPERAND_WIDTH = 4;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SGT = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

endpackage

// File: rtl/micro_processor_if.sv
// micro_processor_if: board-side signal bundle of the push-button ALU.
//   data_in  : operands, A = [7:4], B = [3:0]
//   pb       : raw active-high push buttons (asynchronous)
//   data_out : registered ALU result
//   opcode   : current opcode register
//   button   : debounced button levels
// master = board/stimulus side, slave = the processor.
interface micro_processor_if;

  logic [7:0] data_in;
  logic [2:0] pb;
  logic [7:0] data_out;
  logic [2:0] opcode;
  logic [2:0] button;

  modport master (
    output data_in,
    output pb,
    input  data_out,
    input  opcode,
    input  button
  );

  modport slave (
    input  data_in,
    input  pb,
    output data_out,
    output opcode,
    output button
  );

endinterface

// File: rtl/micro_processor_pb_debounce.sv
// micro_processor_pb_debounce: one-bit synchronizer + debouncer for a raw push button.
//   clk     : system clock
//   rst     : asynchronous active-low reset
//   i_raw   : raw, bouncy button input
//   o_level : debounced level
//   o_rise  : single-cycle strobe, high in the cycle whose edge raises o_level
module micro_processor_pb_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CntW-1:0]        r_cnt;
  logic                   r_level;

  logic [CntW-1:0] w_cnt_d;
  logic            w_level_d;
  logic            w_synced;
  logic            w_differ;
  logic            w_flip;

  assign w_synced = r_sync[SYNC_STAGES-1];
  assign w_differ = (w_synced != r_level);
  assign w_flip   = w_differ && (r_cnt == CntMax);

  always_comb begin
    w_cnt_d   = '0;
    w_level_d = r_level;
    if (w_flip) begin
      w_level_d = w_synced;
    end else if (w_differ) begin
      w_cnt_d = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      // Shift the raw input in at bit 0; the oldest sample sits at the top.
      r_sync  <= (r_sync << 1) | SYNC_STAGES'(i_raw);
      r_cnt   <= w_cnt_d;
      r_level <= w_level_d;
    end
  end

  assign o_level = r_level;
  // Combinational so the opcode register toggles on the same edge the level rises.
  assign o_rise  = w_flip & w_synced;

endmodule

// File: rtl/micro_processor.sv
// micro_processor: 8-bit ALU whose opcode bits are toggled by debounced push buttons.
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : slave side of micro_processor_if (data_in, pb in; data_out, opcode, button out)
module micro_processor
  import micro_processor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic             clk,
  input  logic             rst,
  micro_processor_if.slave bus
);

  logic [2:0] w_level;
  logic [2:0] w_rise;

  logic [OPERAND_WIDTH-1:0] w_a;
  logic [OPERAND_WIDTH-1:0] w_b;
  logic [7:0]               w_alu;

  logic [2:0] r_opcode;
  logic [7:0] r_data_out;

  for (genvar gi = 0; gi < 3; gi++) begin : g_pb
    micro_processor_pb_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_pb_debounce (
      .clk     (clk),
      .rst     (rst),
      .i_raw   (bus.pb[gi]),
      .o_level (w_level[gi]),
      .o_rise  (w_rise[gi])
    );
  end

  assign w_a = bus.data_in[7:4];
  assign w_b = bus.data_in[3:0];

  always_comb begin
    w_alu = 8'h00;
    unique case (r_opcode)
      OP_NOP:  w_alu = 8'h00;
      OP_ADD:  w_alu = {4'h0, w_a} + {4'h0, w_b};
      OP_AND:  w_alu = {4'h0, w_a & w_b};
      OP_OR:   w_alu = {4'h0, w_a | w_b};
      OP_MUL:  w_alu = {4'h0, w_a} * {4'h0, w_b};
      OP_SLT:  w_alu = {7'h00, (w_a < w_b)};
      OP_SGT:  w_alu = {7'h00, (w_a > w_b)};
      OP_XOR:  w_alu = {4'h0, w_a ^ w_b};
      default: w_alu = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_opcode   <= OP_NOP;
      r_data_out <= 8'h00;
    end else begin
      // Each press strobe flips its own opcode bit; simultaneous presses flip together.
      r_opcode   <= r_opcode ^ w_rise;
      r_data_out <= w_alu;
    end
  end

  assign bus.opcode   = r_opcode;
  assign bus.data_out = r_data_out;
  assign bus.button   = w_level;

endmodule

// File: tb/tb_micro_processor.sv
module tb_micro_processor;

  localparam int unsigned DEBOUNCE_CYCLES = 8;
  localparam int unsigned SYNC_STAGES     = 2;

  logic clk;
  logic rst;

  micro_processor_if bus ();

  micro_processor #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: raw samples seen SYNC_STAGES edges late; a button flips after the
  // late sample has disagreed with it on DEBOUNCE_CYCLES consecutive edges.
  logic [2:0] m_q[$];
  int         m_run[3];
  logic [2:0] m_btn;
  logic [2:0] m_op;
  logic [7:0] m_dout;

  function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] d);
    int a;
    int b;
    int r;
    a = int'(d[7:4]);
    b = int'(d[3:0]);
    case (op)
      3'd1:    r = a + b;
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a * b;
      3'd5:    r = (a < b) ? 1 : 0;
      3'd6:    r = (a > b) ? 1 : 0;
      3'd7:    r = a ^ b;
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < int'(SYNC_STAGES); i++) m_q.push_back(3'b000);
    for (int i = 0; i < 3; i++) m_run[i] = 0;
    m_btn  = 3'b000;
    m_op   = 3'b000;
    m_dout = 8'h00;
  endtask

  task automatic model_step();
    logic [2:0] late;
    late = m_q.pop_front();
    m_q.push_back(bus.pb);
    m_dout = alu_ref(m_op, bus.data_in);
    for (int i = 0; i < 3; i++) begin
      if (late[i] != m_btn[i]) begin
        m_run[i]++;
        if (m_run[i] == int'(DEBOUNCE_CYCLES)) begin
          m_btn[i] = late[i];
          m_run[i] = 0;
          if (late[i]) m_op[i] = ~m_op[i];
        end
      end else begin
        m_run[i] = 0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset();
    else model_step();
    @(negedge clk);
    check("model_data_out", bus.data_out, m_dout);
    check("model_opcode", {5'b0, bus.opcode}, {5'b0, m_op});
    check("model_button", {5'b0, bus.button}, {5'b0, m_btn});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input logic [2:0] mask, input logic [2:0] exp_op, input logic [7:0] exp_dout,
                       input string tag);
    bus.pb = mask;
    run(20);
    bus.pb = 3'b000;
    run(20);
    check({tag, "_opcode"}, {5'b0, bus.opcode}, {5'b0, exp_op});
    check({tag, "_data_out"}, bus.data_out, exp_dout);
  endtask

  initial begin
    rst         = 1'b0;
    bus.pb      = 3'b111;
    bus.data_in = 8'hA2;
    model_reset();

    // Reset held with buttons pressed.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_data_out", bus.data_out, 8'h00);
      check("rst_opcode", {5'b0, bus.opcode}, 8'h00);
      check("rst_button", {5'b0, bus.button}, 8'h00);
    end
    bus.pb = 3'b000;
    rst    = 1'b1;
    run(4);

    // Bounce rejection: pulses of 1..DEBOUNCE_CYCLES-1 cycles.
    for (int len = 1; len < int'(DEBOUNCE_CYCLES); len++) begin
      bus.pb = 3'b001;
      run(len);
      bus.pb = 3'b000;
      run(4);
    end
    run(12);
    check("bounce_button", {5'b0, bus.button}, 8'h00);
    check("bounce_opcode", {5'b0, bus.opcode}, 8'h00);
    check("bounce_data_out", bus.data_out, 8'h00);

    // Clean press of pb[0]: button rises SYNC_STAGES + DEBOUNCE_CYCLES edges later.
    bus.pb = 3'b001;
    run(int'(SYNC_STAGES + DEBOUNCE_CYCLES) - 1);
    check("add_btn_early", {5'b0, bus.button}, 8'h00);
    run(1);
    check("add_btn_rise", {5'b0, bus.button}, 8'h01);
    check("add_opcode", {5'b0, bus.opcode}, 8'h01);
    check("add_dout_lag", bus.data_out, 8'h00);
    run(1);
    check("add_dout", bus.data_out, 8'h0C);
    run(9);
    bus.pb = 3'b000;
    run(20);
    check("add_release_opcode", {5'b0, bus.opcode}, 8'h01);
    check("add_release_button", {5'b0, bus.button}, 8'h00);

    // Opcode toggling with A=A, B=2.
    press(3'b010, 3'b011, 8'h0A, "or");
    press(3'b001, 3'b010, 8'h02, "and");
    press(3'b101, 3'b111, 8'h08, "xor");

    // Arithmetic corners.
    press(3'b011, 3'b100, 8'h14, "mul_a2");
    bus.data_in = 8'hFF;
    run(2);
    check("mul_ff", bus.data_out, 8'hE1);
    press(3'b101, 3'b001, 8'h1E, "add_ff");
    press(3'b100, 3'b101, 8'h00, "slt_ff");
    bus.data_in = 8'h2A;
    run(2);
    check("slt_2a", bus.data_out, 8'h01);
    bus.data_in = 8'h55;
    run(2);
    check("slt_55", bus.data_out, 8'h00);
    press(3'b011, 3'b110, 8'h00, "sgt_55");
    bus.data_in = 8'h2A;
    run(2);
    check("sgt_2a", bus.data_out, 8'h00);
    bus.data_in = 8'hA2;
    run(2);
    check("sgt_a2", bus.data_out, 8'h01);

    // Asynchronous reset between edges, with pb[1] held through release.
    bus.pb = 3'b010;
    run(3);
    #2;
    rst = 1'b0;
    #1;
    check("arst_data_out", bus.data_out, 8'h00);
    check("arst_opcode", {5'b0, bus.opcode}, 8'h00);
    check("arst_button", {5'b0, bus.button}, 8'h00);
    model_reset();
    run(2);
    rst = 1'b1;
    run(int'(SYNC_STAGES + DEBOUNCE_CYCLES) - 1);
    check("held_btn_early", {5'b0, bus.button}, 8'h00);
    check("held_opcode_early", {5'b0, bus.opcode}, 8'h00);
    run(1);
    check("held_btn_rise", {5'b0, bus.button}, 8'h02);
    check("held_opcode", {5'b0, bus.opcode}, 8'h02);
    bus.pb = 3'b000;
    run(20);

    // Random bouncy buttons and operands against the model.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) bus.pb = 3'($urandom);
      if ($urandom_range(0, 31) == 0) bus.data_in = 8'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/micro_processor.md
Name: micro_processor

Overview:
- Minimal 8-bit ALU "microprocessor" driven by three push buttons.
- data_in carries two 4-bit unsigned operands: A = data_in[7:4], B = data_in[3:0].
- Debounced button presses toggle bits of a 3-bit opcode register. The selected ALU result is registered onto data_out.
- Top-level board block: pb comes from raw switches, data_in from DIP switches, data_out/opcode/button go to LEDs.

Parameters:
- DEBOUNCE_CYCLES, 8, consecutive clk cycles a synchronized pb bit must hold a new level before the debounced level changes.
- SYNC_STAGES, 2, flip-flop synchronizer depth on each pb bit.

Ports:
- clk  input  1  single system clock, all logic rising-edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- data_in  input  8  operands: [7:4] = A, [3:0] = B, unsigned.
- pb  input  3  raw, bouncy push buttons, active-high (1 = pressed), asynchronous to clk.
- data_out  output  8  registered ALU result.
- opcode  output  3  current opcode register.
- button  output  3  debounced pb levels.

Behaviour:
- Reset (rst=0, asynchronous):
  - opcode=3'b000, data_out=8'h00, button=3'b000.
  - Debounce counters and synchronizers cleared to 0.
  - Reset release is synchronous in effect: first update on the first clk edge with rst=1.
- Synchronization: each pb[i] passes through SYNC_STAGES flops before debounce.
- Debounce, per bit, independent:
  - Counter increments while the synchronized level differs from button[i]. It clears to 0 whenever the two are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, button[i] takes the new level and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES cycles never change button[i].
- Press event: single-cycle strobe on the button[i] 0->1 transition. Releases (1->0) generate no event.
- Opcode update:
  - On a press event of bit i, opcode[i] toggles on the same clk edge that button[i] rises.
  - Simultaneous events on several bits toggle each corresponding opcode bit in the same cycle.
  - Opcode holds otherwise.
- ALU, combinational from A, B, opcode; result zero-extended to 8 bits:
  - 000 NOP: 8'h00
  - 001 ADD: A+B, 5-bit result, max 30
  - 010 AND: A&B
  - 011 OR: A|B
  - 100 MUL: A*B, 8-bit result, max 225, no overflow possible
  - 101 SLT: 1 if A<B else 0
  - 110 SGT: 1 if A>B else 0
  - 111 XOR: A^B
- data_out <= ALU result on every clk edge when not in reset. Latency is 1 cycle from any data_in or opcode change.
- An opcode change is visible on data_out one cycle after the opcode register updates.
- data_in is assumed static or synchronous. No synchronizer on data_in; a change is reflected one cycle later.
- Boundaries:
  - A=B=15: ADD gives 30 (8'h1E), MUL gives 225 (8'hE1).
  - A=B: SLT and SGT both give 0.
  - Reset mid-debounce discards the pending transition.
  - A button held through reset release needs a full DEBOUNCE_CYCLES stable period before it registers as a press.

Decomposition:
- Shared package: 3-bit opcode constants OP_NOP, OP_ADD, OP_AND, OP_OR, OP_MUL, OP_SLT, OP_SGT, OP_XOR, and the operand width constant (4).
- One sub-module: pb_debounce, 1 bit wide, parameterized by DEBOUNCE_CYCLES and SYNC_STAGES.
  - Ports: clk, rst, raw in, level out, rise strobe out.
  - Instantiated three times.
- ALU and opcode register live inline in the top.

Test Plan:
- Reset: hold rst=0 with pb=3'b111 and data_in=8'hA2 -> data_out=0, opcode=0, button=0 throughout reset.
- Bounce rejection: release reset, data_in=8'hA2. Pulse pb[0] high for fewer than DEBOUNCE_CYCLES cycles several times -> button and opcode unchanged, data_out=0.
- ADD: then hold pb[0]=1 for 20 cycles -> button[0]=1 after sync + DEBOUNCE_CYCLES, opcode=001, data_out=8'h0C one cycle later. Releasing pb[0] leaves opcode=001.
- Opcode toggling: with data_in=8'hA2, cleanly press pb[1] (opcode=011) -> OR=8'h0A. Press pb[0] (opcode=010) -> AND=8'h02. Press pb[2] and pb[0] (opcode=111) -> XOR=8'h08.
- Arithmetic corners: opcode=100 with data_in=8'hFF -> 8'hE1. opcode=001 with data_in=8'hFF -> 8'h1E. opcode=101/110 with data_in=8'h2A -> 1/0. Same opcodes with data_in=8'h55 -> 0/0.
- Async reset mid-operation: assert rst=0 between clk edges while opcode=110 -> outputs clear immediately without a clock edge. After release, opcode=000 and data_out=0.
